// File: rtl/sti_pkg.sv
// rtl/sti_pkg.sv - shared types, state encoding and length decode for the STI receiver
package sti_pkg;

    typedef enum logic [1:0] {
        LEN_8  = 2'b00,
        LEN_16 = 2'b01,
        LEN_24 = 2'b10,
        LEN_32 = 2'b11
    } len_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    typedef struct packed {
        len_e length;
        logic msb;
        logic fill;
        logic low;
    } cfg_t;

    function automatic logic [5:0] len_bits(input len_e code);
        logic [5:0] n;
        case (code)
            LEN_8:   n = 6'd8;
            LEN_16:  n = 6'd16;
            LEN_24:  n = 6'd24;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sti_frame_unpack.sv
// rtl/sti_frame_unpack.sv - selects the 16-bit parallel word out of a right-aligned raw frame
module sti_frame_unpack
    import sti_pkg::*;
(
    input  logic [31:0] frame_i,
    input  len_e        length_i,
    input  logic        fill_i,
    input  logic        low_i,
    output logic [15:0] data_o
);

    always_comb begin
        data_o = frame_i[15:0];
        case (length_i)
            LEN_8:   data_o = low_i ? {frame_i[7:0], 8'h00} : {8'h00, frame_i[7:0]};
            LEN_16:  data_o = frame_i[15:0];
            LEN_24:  data_o = fill_i ? frame_i[23:8] : frame_i[15:0];
            LEN_32:  data_o = fill_i ? frame_i[31:16] : frame_i[15:0];
            default: data_o = frame_i[15:0];
        endcase
    end

endmodule

// File: rtl/sti_receiver.sv
// rtl/sti_receiver.sv - serial-to-parallel frame receiver with configurable length and bit order
module sti_receiver
    import sti_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic        si_end,
    input  logic        cfg_load,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        cfg_fill,
    input  logic        cfg_low,
    output logic [15:0] po_data,
    output logic [31:0] po_frame,
    output logic        po_valid,
    output logic        rx_error,
    output logic        rx_busy,
    output logic        rx_done,
    output logic [7:0]  frame_cnt
);

    state_e      state_q;
    cfg_t        cfg_q;
    cfg_t        cfg_in;
    cfg_t        cfg_eff;
    logic [5:0]  bit_cnt_q;
    logic [31:0] shreg_q;
    logic [31:0] shift_d;
    logic        end_pending_q;
    logic        end_now;
    logic        last_bit;
    logic [15:0] unpack_data;
    logic [15:0] po_data_q;
    logic [31:0] po_frame_q;
    logic        po_valid_q;
    logic        rx_error_q;
    logic [7:0]  frame_cnt_q;

    assign cfg_in = '{length: len_e'(cfg_length), msb: cfg_msb, fill: cfg_fill, low: cfg_low};

    always_comb begin
        // A frame may start on the very edge that loads a new config.
        cfg_eff = ((state_q == ST_IDLE) && cfg_load) ? cfg_in : cfg_q;
        shift_d = shreg_q;
        if (cfg_eff.msb) begin
            shift_d = {shreg_q[30:0], si_data};
        end else begin
            shift_d[bit_cnt_q[4:0]] = si_data;
        end
        last_bit = ((bit_cnt_q + 6'd1) == len_bits(cfg_q.length));
        end_now  = end_pending_q | si_end;
    end

    sti_frame_unpack u_unpack (
        .frame_i  (shift_d),
        .length_i (cfg_q.length),
        .fill_i   (cfg_q.fill),
        .low_i    (cfg_q.low),
        .data_o   (unpack_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cfg_q         <= '{length: LEN_8, msb: 1'b0, fill: 1'b0, low: 1'b0};
            bit_cnt_q     <= 6'd0;
            shreg_q       <= 32'd0;
            end_pending_q <= 1'b0;
            po_data_q     <= 16'd0;
            po_frame_q    <= 32'd0;
            po_valid_q    <= 1'b0;
            rx_error_q    <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            po_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_load) begin
                        cfg_q <= cfg_in;
                    end
                    if (si_valid) begin
                        shreg_q   <= shift_d;
                        bit_cnt_q <= 6'd1;
                        state_q   <= ST_RECV;
                    end else if (si_end) begin
                        state_q <= ST_FIN;
                    end
                end
                ST_RECV: begin
                    if (si_end) begin
                        end_pending_q <= 1'b1;
                    end
                    if (si_valid && !last_bit) begin
                        shreg_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                    end else begin
                        // Frame ends here, either complete or aborted.
                        if (si_valid) begin
                            po_valid_q  <= 1'b1;
                            po_frame_q  <= shift_d;
                            po_data_q   <= unpack_data;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            rx_error_q <= 1'b1;
                        end
                        shreg_q       <= 32'd0;
                        bit_cnt_q     <= 6'd0;
                        end_pending_q <= 1'b0;
                        state_q       <= end_now ? ST_FIN : ST_IDLE;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_FIN;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign po_data   = po_data_q;
    assign po_frame  = po_frame_q;
    assign po_valid  = po_valid_q;
    assign rx_error  = rx_error_q;
    assign frame_cnt = frame_cnt_q;
    assign rx_busy   = (state_q == ST_RECV);
    assign rx_done   = (state_q == ST_FIN);

endmodule

// File: tb/tb_sti_receiver.sv
// tb/tb_sti_receiver.sv - directed self-checking bench for sti_receiver
module tb_sti_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        si_data = 1'b0;
    logic        si_valid = 1'b0;
    logic        si_end = 1'b0;
    logic        cfg_load = 1'b0;
    logic [1:0]  cfg_length = 2'b00;
    logic        cfg_msb = 1'b0;
    logic        cfg_fill = 1'b0;
    logic        cfg_low = 1'b0;
    logic [15:0] po_data;
    logic [31:0] po_frame;
    logic        po_valid;
    logic        rx_error;
    logic        rx_busy;
    logic        rx_done;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [1:0]  len;
        logic        msb;
        logic        fill;
        logic        low;
        logic [31:0] frame;
        logic [15:0] exp_data;
        logic [31:0] exp_frame;
    } vec_t;

    vec_t vec [7];

    sti_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .si_end     (si_end),
        .cfg_load   (cfg_load),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .cfg_fill   (cfg_fill),
        .cfg_low    (cfg_low),
        .po_data    (po_data),
        .po_frame   (po_frame),
        .po_valid   (po_valid),
        .rx_error   (rx_error),
        .rx_busy    (rx_busy),
        .rx_done    (rx_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [31:0] frame, input int n, input logic msb, input int i);
        return msb ? frame[n-1-i] : frame[i];
    endfunction

    task automatic load_cfg(input logic [1:0] len, input logic msb, input logic fill, input logic low);
        @(negedge clk);
        cfg_load = 1'b1; cfg_length = len; cfg_msb = msb; cfg_fill = fill; cfg_low = low;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Leaves the bench at the negedge after the last bit, where the result is visible.
    task automatic send_frame(input logic [1:0] len, input logic msb, input logic fill,
                              input logic low, input logic [31:0] frame);
        int n;
        n = (int'(len) + 1) * 8;
        load_cfg(len, msb, fill, low);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            si_valid = 1'b1;
            si_data  = bit_of(frame, n, msb, i);
        end
        @(negedge clk);
        si_valid = 1'b0;
        si_data  = 1'b0;
    endtask

    initial begin
        int pulse_at [2];
        logic [15:0] pulse_data [2];
        int npulse;
        logic bad;

        vec[0] = '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0000A5C3, 16'hA5C3, 32'h0000A5C3};
        vec[1] = '{2'b00, 1'b0, 1'b0, 1'b1, 32'h0000003C, 16'h3C00, 32'h0000003C};
        vec[2] = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h0000BEEF, 16'hBEEF, 32'h0000BEEF};
        vec[3] = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h12340000, 16'h1234, 32'h12340000};
        vec[4] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h000000A7, 16'h00A7, 32'h000000A7};
        vec[5] = '{2'b10, 1'b0, 1'b1, 1'b0, 32'h00ABCDEF, 16'hABCD, 32'h00ABCDEF};
        vec[6] = '{2'b11, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 16'hBEEF, 32'hDEADBEEF};

        repeat (2) @(negedge clk);
        check("rst_po_data", 32'(po_data), 32'h0);
        check("rst_po_frame", po_frame, 32'h0);
        check("rst_pulses", {30'd0, po_valid, rx_error}, 32'h0);
        check("rst_status", {30'd0, rx_busy, rx_done}, 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            send_frame(vec[v].len, vec[v].msb, vec[v].fill, vec[v].low, vec[v].frame);
            exp_cnt++;
            check($sformatf("vec%0d_po_valid", v), 32'(po_valid), 32'h1);
            check($sformatf("vec%0d_po_data", v), 32'(po_data), 32'(vec[v].exp_data));
            check($sformatf("vec%0d_po_frame", v), po_frame, vec[v].exp_frame);
            check($sformatf("vec%0d_frame_cnt", v), 32'(frame_cnt), 32'(exp_cnt[7:0]));
            @(negedge clk);
            check($sformatf("vec%0d_pulse_len", v), 32'(po_valid), 32'h0);
        end

        // Back-to-back 8-bit frames with si_valid held for 16 cycles.
        load_cfg(2'b00, 1'b1, 1'b0, 1'b0);
        npulse = 0;
        pulse_at[0] = -1; pulse_at[1] = -1;
        pulse_data[0] = 16'h0; pulse_data[1] = 16'h0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (po_valid) begin
                if (npulse < 2) begin
                    pulse_at[npulse] = i;
                    pulse_data[npulse] = po_data;
                end
                npulse++;
            end
            if (i < 8) begin
                si_valid = 1'b1; si_data = bit_of(32'h81, 8, 1'b1, i);
            end else if (i < 16) begin
                si_valid = 1'b1; si_data = bit_of(32'h7E, 8, 1'b1, i - 8);
            end else begin
                si_valid = 1'b0; si_data = 1'b0;
            end
        end
        exp_cnt += 2;
        check("b2b_npulse", 32'(npulse), 32'd2);
        check("b2b_first_at", 32'(pulse_at[0]), 32'd8);
        check("b2b_gap", 32'(pulse_at[1] - pulse_at[0]), 32'd8);
        check("b2b_data0", 32'(pulse_data[0]), 32'h0081);
        check("b2b_data1", 32'(pulse_data[1]), 32'h007E);
        check("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_cnt[7:0]));

        // Abort after 5 bits, then a full frame.
        load_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            si_valid = 1'b1; si_data = 1'b1;
        end
        @(negedge clk);
        check("abort_busy", 32'(rx_busy), 32'h1);
        si_valid = 1'b0;
        @(negedge clk);
        check("abort_rx_error", 32'(rx_error), 32'h1);
        check("abort_no_valid", 32'(po_valid), 32'h0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'(exp_cnt[7:0]));
        check("abort_po_data", 32'(po_data), 32'h007E);
        check("abort_idle", 32'(rx_busy), 32'h0);
        @(negedge clk);
        check("abort_pulse_len", 32'(rx_error), 32'h0);
        send_frame(2'b01, 1'b1, 1'b0, 1'b0, 32'h00001357);
        exp_cnt++;
        check("after_abort_valid", 32'(po_valid), 32'h1);
        check("after_abort_data", 32'(po_data), 32'h1357);
        check("after_abort_cnt", 32'(frame_cnt), 32'(exp_cnt[7:0]));

        // si_end during bit 3 of a 16-bit frame.
        load_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            si_valid = 1'b1;
            si_data  = bit_of(32'h2468, 16, 1'b1, i);
            si_end   = (i == 2);
        end
        @(negedge clk);
        si_valid = 1'b0;
        exp_cnt++;
        check("end_po_valid", 32'(po_valid), 32'h1);
        check("end_po_data", 32'(po_data), 32'h2468);
        check("end_rx_done", 32'(rx_done), 32'h1);
        check("end_frame_cnt", 32'(frame_cnt), 32'(exp_cnt[7:0]));
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0 && (po_valid || rx_error)) bad = 1'b1;
            si_valid = 1'b1; si_data = 1'($urandom); cfg_load = 1'b1; si_end = (i == 5);
        end
        @(negedge clk);
        si_valid = 1'b0; cfg_load = 1'b0; si_end = 1'b0;
        if (po_valid || rx_error) bad = 1'b1;
        check("fin_no_pulses", 32'(bad), 32'h0);
        check("fin_sticky", {30'd0, rx_done, rx_busy}, 32'h2);
        check("fin_frame_cnt", 32'(frame_cnt), 32'(exp_cnt[7:0]));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        check("rerst_status", {30'd0, rx_done, rx_busy}, 32'h0);
        check("rerst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("rerst_po_data", 32'(po_data), 32'h0);

        // Reset mid-frame must not pulse anything; then the config must be back to defaults.
        load_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            si_valid = 1'b1; si_data = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1; si_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_pulses", {30'd0, po_valid, rx_error}, 32'h0);
        check("midrst_busy", 32'(rx_busy), 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            si_valid = 1'b1; si_data = bit_of(32'h5A, 8, 1'b0, i);
        end
        @(negedge clk);
        si_valid = 1'b0;
        check("default_cfg_valid", 32'(po_valid), 32'h1);
        check("default_cfg_data", 32'(po_data), 32'h005A);
        check("default_cfg_cnt", 32'(frame_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk) begin
        if (!reset && po_valid && rx_error) begin
            failures++;
            $display("FAIL pulse_overlap: po_valid=%b rx_error=%b required not both high", po_valid, rx_error);
        end
    end

endmodule

// File: doc/sti_receiver.md
STI_RECEIVER -- requirements
Module: sti_receiver

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port si_data, input, 1, serial data bit, sampled when si_valid=1.
REQ-004 SHALL have port si_valid, input, 1, serial bit qualifier; stays high for a whole frame.
REQ-005 SHALL have port si_end, input, 1, end-of-stream indication.
REQ-006 SHALL have port cfg_load, input, 1, latches cfg_* on a clock edge while in IDLE.
REQ-007 SHALL have port cfg_length, input, 2, frame length code: 00=8, 01=16, 10=24, 11=32 bits.
REQ-008 SHALL have ports cfg_msb, cfg_fill and cfg_low, inputs, 1 each: MSB-first order; data in upper half for 24/32-bit frames; 8-bit byte placed in po_data[15:8].
REQ-009 SHALL have port po_data, output, 16, recovered parallel word.
REQ-010 SHALL have port po_frame, output, 32, raw frame, right-aligned, zero-extended.
REQ-011 SHALL have ports po_valid and rx_error, outputs, 1 each, one-cycle pulses: frame complete; frame aborted.
REQ-012 SHALL have ports rx_busy and rx_done, outputs, 1 each: frame in progress (RECV); stream finished (FIN, sticky).
REQ-013 SHALL have port frame_cnt, output, 8, count of good frames, wraps 255->0.

Function
REQ-014 States SHALL be IDLE, RECV and FIN.
REQ-015 IDLE: cfg_load=1 latches config. If si_valid=1, the bit is shifted in as bit 1 and the state goes to RECV. Otherwise, if si_end=1, the state goes to FIN. si_valid takes priority over si_end.
REQ-016 RECV: each cycle with si_valid=1 shifts in one bit and increments bit_cnt (6-bit).
REQ-017 When bit L is sampled, the state SHALL return to IDLE and po_valid, po_data and po_frame SHALL update on the next edge (latency of 1 cycle after the last bit).
REQ-018 Back-to-back frames: si_valid held high across the boundary SHALL start the next frame with no gap cycle.
REQ-019 si_valid=0 in RECV before bit L SHALL pulse rx_error for 1 cycle, discard the partial frame, return to IDLE, and leave po_* and frame_cnt unchanged.
REQ-020 si_end=1 in RECV SHALL set end_pending. The current frame then completes or aborts normally and the next state is FIN instead of IDLE.
REQ-021 FIN: rx_done=1 and the block SHALL ignore si_valid, si_end and cfg_load. FIN is left only by reset.
REQ-022 cfg_load outside IDLE SHALL be ignored; config is stable for a whole frame.
REQ-023 Bit order: with cfg_msb=1, frame bit L-1 arrives first (shift left, insert at LSB). With cfg_msb=0, frame bit 0 arrives first and is placed at position k for the k-th bit (0-based).
REQ-024 Unpack to po_data:
- L=8: byte goes to [15:8] if cfg_low=1, else to [7:0]; the other byte is 0.
- L=16: frame[15:0].
- L=24: frame[23:8] if cfg_fill=1, else frame[15:0].
- L=32: frame[31:16] if cfg_fill=1, else frame[15:0].
REQ-025 frame_cnt SHALL increment with each po_valid pulse.
REQ-026 po_valid and rx_error SHALL never be high together.

Reset
REQ-027 Reset SHALL force state=IDLE, all outputs 0, bit_cnt=0, end_pending=0, shift register 0, and config to length=00 with all flags 0.
REQ-028 Reset mid-frame SHALL discard the frame without any rx_error or po_valid pulse.

Structure
REQ-029 Package sti_pkg SHALL hold the length codes, the state encoding, and a length-code-to-bit-count function (8/16/24/32).
REQ-030 Combinational sub-module sti_frame_unpack SHALL implement REQ-024; everything else stays in sti_receiver.

Verification
REQ-031 Scenario: length=01, msb=1, 16 bits of 0xA5C3 -> po_valid pulse one cycle after bit 16, po_data=0xA5C3, po_frame=0x0000A5C3, frame_cnt=1.
REQ-032 Scenario: length=00, low=1, msb=0, byte 0x3C sent LSB-first -> po_data=0x3C00, po_frame=0x0000003C.
REQ-033 Scenario: length=10, fill=0, msb=1, frame 0x00BEEF -> po_data=0xBEEF. Repeat with length=11, fill=1, frame 0x12340000 -> po_data=0x1234.
REQ-034 Scenario: two 8-bit frames 0x81, 0x7E with si_valid high for 16 continuous cycles -> two po_valid pulses 8 cycles apart, frame_cnt=2.
REQ-035 Scenario: si_valid drops after 5 bits -> rx_error pulse, no po_valid, frame_cnt unchanged; the next full frame is received correctly.
REQ-036 Scenario: si_end pulsed at bit 3 of a 16-bit frame -> frame completes with po_valid, then rx_done=1; later si_valid activity produces no pulses; reset returns the block to IDLE.
